// File: rtl/signal_sequencer.sv
// signal_sequencer: four-road traffic light phase sequencer (GREEN -> YELLOW -> ALLRED -> next road)
//   in : clk, reset (async, active-high), tick (timebase pulse), hold (freezes timer),
//        TGn/TGe/TGs/TGw (requested green ticks per road)
//   out: current_road, next_road, light_n/e/s/w (00 red, 01 yellow, 10 green),
//        timer (ticks left in state), green_start (first cycle of each green)
module signal_sequencer #(
  parameter int TY   = 3,
  parameter int TR   = 1,
  parameter int TMIN = 5,
  parameter int TMAX = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       hold,
  input  logic [7:0] TGn,
  input  logic [7:0] TGe,
  input  logic [7:0] TGs,
  input  logic [7:0] TGw,
  output logic [1:0] current_road,
  output logic [1:0] next_road,
  output logic [1:0] light_n,
  output logic [1:0] light_e,
  output logic [1:0] light_s,
  output logic [1:0] light_w,
  output logic [7:0] timer,
  output logic       green_start
);
  typedef enum logic [1:0] {ALLRED, GREEN, YELLOW} state_t;
  localparam logic [7:0] TY8   = 8'(TY);
  localparam logic [7:0] TR8   = 8'(TR);
  localparam logic [7:0] TMIN8 = 8'(TMIN);
  localparam logic [7:0] TMAX8 = 8'(TMAX);
  localparam logic [7:0] TINIT = (TR > 0) ? TR8 : 8'd1;
  localparam bit HAS_ALLRED = (TR > 0);
  state_t     r_state, w_state;
  logic [1:0] r_road, w_road, r_next_road;
  logic [7:0] r_timer, w_timer, w_tg, w_tg_clamp;
  logic [7:0] r_lights, w_lights;
  logic       r_gs, w_gs, w_consume, w_last;
  assign w_consume  = tick & ~hold;
  assign w_last     = r_timer == 8'd1;
  // requested green of the road about to go green, sampled only on the entry edge
  assign w_tg       = (r_next_road == 2'd0) ? TGn : (r_next_road == 2'd1) ? TGe :
                      (r_next_road == 2'd2) ? TGs : TGw;
  assign w_tg_clamp = (w_tg < TMIN8) ? TMIN8 : (w_tg > TMAX8) ? TMAX8 : w_tg;
  always_comb begin
    w_state = r_state;
    w_timer = r_timer;
    w_road  = r_road;
    w_gs    = 1'b0;
    if (w_consume && !w_last) w_timer = r_timer - 8'd1;
    else if (w_consume) begin
      if (r_state == GREEN) begin
        w_state = YELLOW;
        w_timer = TY8;
      end else if (r_state == YELLOW && HAS_ALLRED) begin
        w_state = ALLRED;
        w_timer = TR8;
      end else begin
        w_state = GREEN;
        w_road  = r_next_road;
        w_timer = w_tg_clamp;
        w_gs    = 1'b1;
      end
    end
  end
  always_comb begin
    w_lights = 8'd0;
    for (int i = 0; i < 4; i++)
      if (w_road == 2'(i))
        w_lights[7-2*i -: 2] = (w_state == GREEN) ? 2'b10 : (w_state == YELLOW) ? 2'b01 : 2'b00;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ALLRED;
      r_road      <= 2'd3;
      r_next_road <= 2'd0;
      r_timer     <= TINIT;
      r_lights    <= 8'd0;
      r_gs        <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_road      <= w_road;
      r_next_road <= w_road + 2'd1;
      r_timer     <= w_timer;
      r_lights    <= w_lights;
      r_gs        <= w_gs;
    end
  end
  assign current_road = r_road;
  assign next_road    = r_next_road;
  assign light_n      = r_lights[7:6];
  assign light_e      = r_lights[5:4];
  assign light_s      = r_lights[3:2];
  assign light_w      = r_lights[1:0];
  assign timer        = r_timer;
  assign green_start  = r_gs;
endmodule

// File: tb/tb_signal_sequencer.sv
// tb_signal_sequencer: directed self-checking bench for signal_sequencer (default build and TR=0 build)
module tb_signal_sequencer;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, tick_b = 1'b0, hold = 1'b0;
  logic [7:0] TGn = 8'd20, TGe = 8'd0, TGs = 8'd200, TGw = 8'd7;
  logic [1:0] road, nroad, ln, le, ls, lw;
  logic [1:0] road_b, nroad_b, ln_b, le_b, ls_b, lw_b;
  logic [7:0] tmr, tmr_b;
  logic gs, gs_b;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  signal_sequencer dut (
    .clk(clk), .reset(reset), .tick(tick), .hold(hold),
    .TGn(TGn), .TGe(TGe), .TGs(TGs), .TGw(TGw),
    .current_road(road), .next_road(nroad),
    .light_n(ln), .light_e(le), .light_s(ls), .light_w(lw),
    .timer(tmr), .green_start(gs)
  );
  signal_sequencer #(.TR(0)) dut_b (
    .clk(clk), .reset(reset), .tick(tick_b), .hold(hold),
    .TGn(TGn), .TGe(TGe), .TGs(TGs), .TGw(TGw),
    .current_road(road_b), .next_road(nroad_b),
    .light_n(ln_b), .light_e(le_b), .light_s(ls_b), .light_w(lw_b),
    .timer(tmr_b), .green_start(gs_b)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic ta, input logic h, input logic tb);
    @(negedge clk);
    tick = ta;
    hold = h;
    tick_b = tb;
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0);
  endtask
  task automatic ticks_b(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_road", road, 2'd3);
    chk("rst_next", nroad, 2'd0);
    chk("rst_timer", tmr, 8'd1);
    chk("rst_lights", {ln, le, ls, lw}, 8'h00);
    chk("rst_gs", gs, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    chk("n_green_lights", {ln, le, ls, lw}, 8'b10_00_00_00);
    chk("n_green_timer", tmr, 8'd20);
    chk("n_green_gs", gs, 1'b1);
    chk("n_green_road", road, 2'd0);
    chk("n_green_next", nroad, 2'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("gs_one_cycle", gs, 1'b0);
    chk("no_tick_timer", tmr, 8'd20);
    ticks(8);
    chk("timer_12", tmr, 8'd12);
    repeat (10) step(1'b1, 1'b1, 1'b0);
    chk("hold_timer", tmr, 8'd12);
    chk("hold_lights", {ln, le, ls, lw}, 8'b10_00_00_00);
    chk("hold_gs", gs, 1'b0);
    ticks(1);
    chk("resume_timer", tmr, 8'd11);
    ticks(10);
    chk("n_green_last", {ln, tmr}, {2'b10, 8'd1});
    ticks(1);
    chk("n_yellow", {ln, le, ls, lw}, 8'b01_00_00_00);
    chk("n_yellow_timer", tmr, 8'd3);
    ticks(3);
    chk("allred_lights", {ln, le, ls, lw}, 8'h00);
    chk("allred_timer", tmr, 8'd1);
    chk("allred_road", road, 2'd0);
    ticks(1);
    chk("e_green_lights", {ln, le, ls, lw}, 8'b00_10_00_00);
    chk("e_green_min", tmr, 8'd5);
    chk("e_green_road", {road, nroad}, {2'd1, 2'd2});
    chk("e_green_gs", gs, 1'b1);
    ticks(5);
    chk("e_yellow", {ln, le, ls, lw, tmr}, {8'b00_01_00_00, 8'd3});
    ticks(4);
    chk("s_green_max", tmr, 8'd60);
    chk("s_green_lights", {ln, le, ls, lw, 6'b0, road}, {8'b00_00_10_00, 8'd2});
    ticks(59);
    chk("s_green_last", {ls, tmr}, {2'b10, 8'd1});
    ticks(1);
    chk("s_yellow", {ln, le, ls, lw, tmr}, {8'b00_00_01_00, 8'd3});
    ticks(4);
    chk("w_green", {ln, le, ls, lw, tmr}, {8'b00_00_00_10, 8'd7});
    chk("w_green_road", {road, nroad}, {2'd3, 2'd0});
    TGw = 8'd100;
    TGn = 8'd30;
    ticks(1);
    chk("tg_change_ignored", tmr, 8'd6);
    ticks(6);
    chk("w_yellow", {ln, le, ls, lw}, 8'b00_00_00_01);
    ticks(4);
    chk("wrap_road", {road, nroad}, {2'd0, 2'd1});
    chk("wrap_n_green", {ln, le, ls, lw, tmr}, {8'b10_00_00_00, 8'd30});
    ticks(31);
    chk("pre_reset_yellow", {ln, tmr}, {2'b01, 8'd2});
    @(negedge clk);
    #1;
    reset = 1'b1;
    tick = 1'b0;
    #1;
    chk("async_lights", {ln, le, ls, lw}, 8'h00);
    chk("async_timer", tmr, 8'd1);
    chk("async_road", {road, nroad}, {2'd3, 2'd0});
    chk("async_gs", gs, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    chk("post_reset_n", {ln, le, ls, lw, tmr}, {8'b10_00_00_00, 8'd30});
    chk("post_reset_gs", {gs, road}, {1'b1, 2'd0});
    TGn = 8'd6;
    TGe = 8'd9;
    chk("b_rst_timer", {tmr_b, road_b}, {8'd1, 2'd3});
    ticks_b(1);
    chk("b_n_green", {ln_b, le_b, ls_b, lw_b, tmr_b}, {8'b10_00_00_00, 8'd6});
    ticks_b(6);
    chk("b_n_yellow", {ln_b, tmr_b}, {2'b01, 8'd3});
    ticks_b(3);
    chk("b_e_green_direct", {ln_b, le_b, ls_b, lw_b, tmr_b}, {8'b00_10_00_00, 8'd9});
    chk("b_e_green_gs", {gs_b, road_b, nroad_b}, {1'b1, 2'd1, 2'd2});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
